// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: access size, FSM state, latched
// request, registered bus and response bundles, plus the alignment rule.
package load_store_unit_pkg;

   // Encoding matches funct3[1:0] of the load/store instructions.
   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_BUS,
      LSU_RESP
   } lsu_state_t;

   // Only the request fields still needed after the bus outputs are loaded.
   typedef struct packed {
      logic       is_store;
      mem_size_t  size;
      logic       is_unsigned;
      logic [1:0] addr_lo;
      logic [4:0] rd;
   } lsu_req_t;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } lsu_bus_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
      logic [4:0]  rd;
      logic        error;
   } lsu_resp_t;

   // Size code 3 is illegal and reported the same way as a misalignment.
   function automatic logic is_aligned(mem_size_t size, logic [1:0] addr_lo);
      case (size)
         MEM_BYTE: return 1'b1;
         MEM_HALF: return ~addr_lo[0];
         MEM_WORD: return (addr_lo == 2'b00);
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Interfaces around the load/store unit.
//   lsu_req_if : execute stage (master) -> load/store unit (slave),
//                request handshake plus writeback response.
//   lsu_mem_if : load/store unit (master) -> data memory (slave),
//                single-outstanding req/ack bus.
interface lsu_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [1:0]  req_size;
   logic        req_is_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_error;

   modport master (
      output req_valid, req_is_store, req_size, req_is_unsigned,
             req_addr, req_wdata, req_rd,
      input  req_ready, resp_valid, resp_data, resp_rd, resp_error
   );

   modport slave (
      input  req_valid, req_is_store, req_size, req_is_unsigned,
             req_addr, req_wdata, req_rd,
      output req_ready, resp_valid, resp_data, resp_rd, resp_error
   );
endinterface

interface lsu_mem_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/load_store_unit_load_align.sv
// lsu_load_align: picks the addressed byte/half lane out of a bus word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//   rdata       : raw word from the data bus
//   addr_lo     : byte offset of the access within the word
//   size        : access size
//   is_unsigned : zero-extend instead of sign-extend
//   data        : extended load result
module lsu_load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  mem_size_t   size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      case (addr_lo)
         2'd0:    lane_b = rdata[7:0];
         2'd1:    lane_b = rdata[15:8];
         2'd2:    lane_b = rdata[23:16];
         default: lane_b = rdata[31:24];
      endcase
      // Halfwords reaching here are aligned, so only addr_lo[1] matters.
      lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (size)
         MEM_BYTE: data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
         MEM_HALF: data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
         MEM_WORD: data = rdata;
         default:  data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage behind the ALU. Accepts one load/store at a
// time, drives a req/ack data bus with aligned address, byte enables and
// lane-replicated store data, and returns extended load data with its tag.
//   clk, reset : clock, asynchronous active-high reset
//   req        : lsu_req_if.slave  - request handshake and writeback response
//   mem        : lsu_mem_if.master - data memory bus
//   TIMEOUT_CYCLES : bus cycles to wait for mem_ack before erroring (0 = never)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LSU_IDLE | req_ready high, waiting for req_valid
// LSU_BUS  | mem_req held with stable bus outputs until ack or timeout
// LSU_RESP | resp_valid pulse for one cycle, no request accepted
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic       clk,
   input  logic       reset,
   lsu_req_if.slave   req,
   lsu_mem_if.master  mem
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   lsu_state_t       state_q, state_n;
   lsu_req_t         req_q, req_n;
   lsu_bus_t         bus_q, bus_n;
   lsu_resp_t        resp_q, resp_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;

   mem_size_t   in_size;
   logic [3:0]  in_be;
   logic [31:0] in_wdata;
   logic [31:0] load_data;

   assign in_size = mem_size_t'(req.req_size);

   always_comb begin
      in_be    = '0;
      in_wdata = req.req_wdata;
      case (in_size)
         MEM_BYTE: begin
            in_be    = 4'b0001 << req.req_addr[1:0];
            in_wdata = {4{req.req_wdata[7:0]}};
         end
         MEM_HALF: begin
            in_be    = 4'b0011 << req.req_addr[1:0];
            in_wdata = {2{req.req_wdata[15:0]}};
         end
         MEM_WORD: begin
            in_be    = 4'b1111;
            in_wdata = req.req_wdata;
         end
         default: begin
            in_be    = '0;
            in_wdata = req.req_wdata;
         end
      endcase
   end

   lsu_load_align u_align (
      .rdata       (mem.mem_rdata),
      .addr_lo     (req_q.addr_lo),
      .size        (req_q.size),
      .is_unsigned (req_q.is_unsigned),
      .data        (load_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= LSU_IDLE;
         req_q   <= '0;
         bus_q   <= '0;
         resp_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         req_q   <= req_n;
         bus_q   <= bus_n;
         resp_q  <= resp_n;
         cnt_q   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state_q;
      req_n   = req_q;
      bus_n   = bus_q;
      resp_n  = resp_q;
      cnt_n   = cnt_q;

      case (state_q)
         LSU_IDLE: begin
            if (req.req_valid) begin
               req_n.is_store    = req.req_is_store;
               req_n.size        = in_size;
               req_n.is_unsigned = req.req_is_unsigned;
               req_n.addr_lo     = req.req_addr[1:0];
               req_n.rd          = req.req_rd;
               if (is_aligned(in_size, req.req_addr[1:0])) begin
                  state_n     = LSU_BUS;
                  cnt_n       = '0;
                  bus_n.req   = 1'b1;
                  bus_n.we    = req.req_is_store;
                  bus_n.addr  = {req.req_addr[31:2], 2'b00};
                  bus_n.be    = in_be;
                  bus_n.wdata = in_wdata;
               end else begin
                  state_n      = LSU_RESP;
                  resp_n.valid = 1'b1;
                  resp_n.data  = '0;
                  resp_n.rd    = req.req_rd;
                  resp_n.error = 1'b1;
               end
            end
         end

         LSU_BUS: begin
            // Ack is checked first so it wins over a timeout in the same cycle.
            if (mem.mem_ack) begin
               state_n      = LSU_RESP;
               bus_n        = '0;
               resp_n.valid = 1'b1;
               resp_n.data  = req_q.is_store ? 32'h0 : load_data;
               resp_n.rd    = req_q.rd;
               resp_n.error = 1'b0;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
               state_n      = LSU_RESP;
               bus_n        = '0;
               resp_n.valid = 1'b1;
               resp_n.data  = '0;
               resp_n.rd    = req_q.rd;
               resp_n.error = 1'b1;
            end else begin
               cnt_n = cnt_q + 1'b1;
            end
         end

         LSU_RESP: begin
            state_n      = LSU_IDLE;
            resp_n.valid = 1'b0;
            resp_n.data  = '0;
            resp_n.error = 1'b0;
         end

         default: state_n = LSU_IDLE;
      endcase
   end

   assign req.req_ready  = (state_q == LSU_IDLE);
   assign req.resp_valid = resp_q.valid;
   assign req.resp_data  = resp_q.data;
   assign req.resp_rd    = resp_q.rd;
   assign req.resp_error = resp_q.error;

   assign mem.mem_req   = bus_q.req;
   assign mem.mem_we    = bus_q.we;
   assign mem.mem_addr  = bus_q.addr;
   assign mem.mem_be    = bus_q.be;
   assign mem.mem_wdata = bus_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic clk = 1'b0;
   logic reset;
   int   pass_cnt = 0;
   int   fail_cnt = 0;
   int   total_cnt = 0;

   lsu_req_if rq ();
   lsu_mem_if mb ();

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (rq),
      .mem   (mb)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      rq.req_valid       = 1'b1;
      rq.req_is_store    = st;
      rq.req_size        = sz;
      rq.req_is_unsigned = uns;
      rq.req_addr        = a;
      rq.req_wdata       = wd;
      rq.req_rd          = rd;
      tick();
      rq.req_valid = 1'b0;
   endtask

   task automatic ack(input logic [31:0] d);
      mb.mem_ack   = 1'b1;
      mb.mem_rdata = d;
      tick();
      mb.mem_ack   = 1'b0;
      mb.mem_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset              = 1'b1;
      rq.req_valid       = 1'b0;
      rq.req_is_store    = 1'b0;
      rq.req_size        = 2'd0;
      rq.req_is_unsigned = 1'b0;
      rq.req_addr        = '0;
      rq.req_wdata       = '0;
      rq.req_rd          = '0;
      mb.mem_ack         = 1'b0;
      mb.mem_rdata       = '0;
      #2;
      check("rst_ready", rq.req_ready, 1);
      check("rst_mem_req", mb.mem_req, 0);
      check("rst_mem_be", mb.mem_be, 0);
      check("rst_mem_addr", mb.mem_addr, 0);
      check("rst_resp_valid", rq.resp_valid, 0);
      check("rst_resp_error", rq.resp_error, 0);
      tick();
      tick();
      reset = 1'b0;

      // stray ack after reset
      ack(32'h1234_5678);
      check("stray_resp_valid", rq.resp_valid, 0);
      check("stray_ready", rq.req_ready, 1);
      check("stray_mem_req", mb.mem_req, 0);

      // word load, ack two cycles after mem_req
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 5'd5);
      check("wl_c1_mem_req", mb.mem_req, 1);
      check("wl_mem_be", mb.mem_be, 4'b1111);
      check("wl_mem_addr", mb.mem_addr, 32'h100);
      check("wl_mem_we", mb.mem_we, 0);
      check("wl_c1_ready", rq.req_ready, 0);
      tick();
      check("wl_c2_mem_req", mb.mem_req, 1);
      check("wl_c2_ready", rq.req_ready, 0);
      tick();
      check("wl_c3_mem_req", mb.mem_req, 1);
      check("wl_c3_ready", rq.req_ready, 0);
      check("wl_c3_no_resp", rq.resp_valid, 0);
      ack(32'hDEAD_BEEF);
      check("wl_resp_valid", rq.resp_valid, 1);
      check("wl_resp_data", rq.resp_data, 32'hDEAD_BEEF);
      check("wl_resp_rd", rq.resp_rd, 5);
      check("wl_resp_error", rq.resp_error, 0);
      check("wl_c4_ready", rq.req_ready, 0);
      check("wl_c4_mem_req", mb.mem_req, 0);
      tick();
      check("wl_c5_ready", rq.req_ready, 1);
      check("wl_c5_resp_valid", rq.resp_valid, 0);

      // signed byte load from lane 3, zero-wait bus
      issue(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 5'd7);
      check("lb_mem_be", mb.mem_be, 4'b1000);
      check("lb_mem_addr", mb.mem_addr, 32'h100);
      ack(32'h8012_3456);
      check("lb_resp_valid", rq.resp_valid, 1);
      check("lb_resp_data", rq.resp_data, 32'hFFFF_FF80);
      check("lb_resp_rd", rq.resp_rd, 7);
      tick();

      // unsigned byte load, same lane
      issue(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 5'd8);
      ack(32'h8012_3456);
      check("lbu_resp_data", rq.resp_data, 32'h0000_0080);
      tick();

      // signed half load, upper half
      issue(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 5'd9);
      check("lh_mem_be", mb.mem_be, 4'b1100);
      check("lh_mem_addr", mb.mem_addr, 32'h200);
      ack(32'h8001_1234);
      check("lh_resp_data", rq.resp_data, 32'hFFFF_8001);
      tick();

      // unsigned half load, lower half
      issue(1'b0, 2'd1, 1'b1, 32'h0000_0200, 32'h0, 5'd10);
      check("lhu_mem_be", mb.mem_be, 4'b0011);
      ack(32'h1234_F00D);
      check("lhu_resp_data", rq.resp_data, 32'h0000_F00D);
      tick();

      // half store
      issue(1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 5'd3);
      check("sh_mem_we", mb.mem_we, 1);
      check("sh_mem_be", mb.mem_be, 4'b1100);
      check("sh_mem_wdata", mb.mem_wdata, 32'hABCD_ABCD);
      check("sh_mem_addr", mb.mem_addr, 32'h100);
      ack(32'hFFFF_FFFF);
      check("sh_resp_valid", rq.resp_valid, 1);
      check("sh_resp_data", rq.resp_data, 0);
      check("sh_resp_rd", rq.resp_rd, 3);
      tick();

      // byte store
      issue(1'b1, 2'd0, 1'b0, 32'h0000_0301, 32'h0000_00A5, 5'd4);
      check("sb_mem_be", mb.mem_be, 4'b0010);
      check("sb_mem_wdata", mb.mem_wdata, 32'hA5A5_A5A5);
      check("sb_mem_addr", mb.mem_addr, 32'h300);
      ack(32'h0);
      tick();

      // misaligned word load
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 5'd9);
      check("mis_c1_resp_valid", rq.resp_valid, 1);
      check("mis_resp_error", rq.resp_error, 1);
      check("mis_resp_data", rq.resp_data, 0);
      check("mis_resp_rd", rq.resp_rd, 9);
      check("mis_c1_mem_req", mb.mem_req, 0);
      check("mis_c1_ready", rq.req_ready, 0);
      tick();
      check("mis_c2_resp_valid", rq.resp_valid, 0);
      check("mis_c2_mem_req", mb.mem_req, 0);
      check("mis_c2_ready", rq.req_ready, 1);

      // misaligned half and illegal size
      issue(1'b1, 2'd1, 1'b0, 32'h0000_0103, 32'hFFFF_FFFF, 5'd1);
      check("mish_mem_req", mb.mem_req, 0);
      check("mish_resp_error", rq.resp_error, 1);
      tick();
      issue(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 5'd2);
      check("ill_mem_req", mb.mem_req, 0);
      check("ill_resp_error", rq.resp_error, 1);
      tick();

      // timeout: mem_req high for 4 cycles, then error response
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, 5'd6);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_mem_req_c%0d", i + 1), mb.mem_req, 1);
         check($sformatf("to_no_resp_c%0d", i + 1), rq.resp_valid, 0);
         tick();
      end
      check("to_mem_req_drop", mb.mem_req, 0);
      check("to_resp_valid", rq.resp_valid, 1);
      check("to_resp_error", rq.resp_error, 1);
      check("to_resp_data", rq.resp_data, 0);
      check("to_resp_rd", rq.resp_rd, 6);
      tick();
      ack(32'hAAAA_AAAA);
      check("to_late_ack_resp", rq.resp_valid, 0);
      check("to_late_ack_ready", rq.req_ready, 1);
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'h0, 5'd12);
      check("to_next_mem_req", mb.mem_req, 1);
      ack(32'h1122_3344);
      check("to_next_resp_data", rq.resp_data, 32'h1122_3344);
      check("to_next_resp_error", rq.resp_error, 0);
      tick();

      // ack in the cycle the timeout would expire wins
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0400, 32'h0, 5'd13);
      tick();
      tick();
      tick();
      check("edge_mem_req_c4", mb.mem_req, 1);
      ack(32'hCAFE_F00D);
      check("edge_resp_valid", rq.resp_valid, 1);
      check("edge_resp_error", rq.resp_error, 0);
      check("edge_resp_data", rq.resp_data, 32'hCAFE_F00D);
      tick();

      // reset during BUS
      issue(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 5'd11);
      tick();
      check("rb_mem_req_before", mb.mem_req, 1);
      reset = 1'b1;
      #1;
      check("rb_mem_req_async", mb.mem_req, 0);
      check("rb_ready_async", rq.req_ready, 1);
      tick();
      tick();
      reset = 1'b0;
      ack(32'h5555_5555);
      check("rb_ack_resp_valid", rq.resp_valid, 0);
      check("rb_ack_ready", rq.req_ready, 1);
      tick();
      check("rb_resp_valid_later", rq.resp_valid, 0);
      issue(1'b0, 2'd0, 1'b1, 32'h0000_0401, 32'h0, 5'd12);
      check("rb_next_mem_be", mb.mem_be, 4'b0010);
      ack(32'h0000_AB00);
      check("rb_next_resp_data", rq.resp_data, 32'h0000_00AB);
      check("rb_next_resp_rd", rq.resp_rd, 12);
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory stage that sits directly downstream of the ALU.
- Takes the ALU-computed effective address plus store data and drives a single-outstanding request/acknowledge data-memory bus.
- Returns aligned, sign/zero-extended load data with its destination register tag for writeback.
- Stalls the pipeline through req_ready while a bus access is in flight; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, default 1024: cycles to wait for mem_ack before aborting with error. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  memory op presented by the execute stage
- req_ready  out  1  unit idle and able to accept a request
- req_is_store  in  1  1 = store, 0 = load
- req_size  in  2  mem_size_t: MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2 (3 is illegal and treated as misaligned)
- req_is_unsigned  in  1  zero-extend load result (LBU/LHU)
- req_addr  in  32 (int32_t)  effective address from the ALU output
- req_wdata  in  32 (int32_t)  rs2 value for stores
- req_rd  in  5  destination register tag
- mem_req  out  1  bus request, held until ack
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  bus completion, one-cycle pulse
- mem_rdata  in  32  read data, valid with mem_ack
- resp_valid  out  1  one-cycle completion pulse
- resp_data  out  32  extended load data; 0 for stores and errors
- resp_rd  out  5  tag of the completed op
- resp_error  out  1  misaligned or timeout

Behaviour:
- Reset (async, any state): state=IDLE, req_ready=1, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_rd=0, resp_error=0, timeout counter=0.
- Outputs are registered, and req_ready=(state==IDLE).
- FSM states:
  - IDLE: on req_valid, latch the request. If aligned, go to BUS; otherwise go to RESP with error=1.
  - BUS: mem_req=1 and all bus outputs held stable. On mem_ack, go to RESP and capture the extracted data. On counter==TIMEOUT_CYCLES-1 with no ack, go to RESP with error=1 and deassert mem_req.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. No request is accepted in RESP.
- Alignment rule: byte is always aligned; half requires addr[0]=0; word requires addr[1:0]=0. A misaligned request never asserts mem_req.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
  - Load requests drive the same mem_be.
- Store data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: select the lane by latched addr[1:0]. Sign-extend bit 7/15 unless req_is_unsigned. Word loads pass through unchanged.
- Latency:
  - Request accepted at cycle 0, mem_req high at cycle 1.
  - mem_ack seen at cycle k gives resp_valid at cycle k+1.
  - Zero-wait bus (ack at cycle 1) gives resp at cycle 2.
  - Misaligned request gives resp at cycle 1.
- Timeout counter: cleared on entry to BUS, increments each BUS cycle without ack. An ack in the same cycle the timeout expires wins, with no error.
- mem_ack outside BUS is ignored. This includes a stray ack after reset.
- Stores complete with resp_data=0; resp_rd carries the latched tag regardless of op.
- Reset during BUS drops mem_req immediately (async). The in-flight response is lost and no resp_valid is produced.

Decomposition:
- Types package additions:
  - mem_size_t enum (values equal funct3[1:0])
  - lsu_state_t enum {LSU_IDLE, LSU_BUS, LSU_RESP}
  - lsu_req_t packed struct for the latched request fields
- Sub-module lsu_load_align: combinational lane select plus extension, inputs (rdata, addr[1:0], size, is_unsigned). Reused by verification as a reference model.
- The byte-enable/replication logic is small and stays inline.

Test Plan:
- Word load addr 0x00000100, ack 2 cycles after mem_req, rdata 0xDEADBEEF -> mem_be=4'b1111, mem_addr=0x100, resp_data=0xDEADBEEF, resp_rd echoed, resp_error=0, req_ready low for 4 cycles.
- Byte load addr 0x00000103, rdata 0x80123456, signed -> mem_be=4'b1000, resp_data=0xFFFFFF80. Same with req_is_unsigned=1 -> 0x00000080.
- Half store addr 0x00000102, wdata 0x1234ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x100, resp_data=0.
- Word load addr 0x00000101 -> mem_req never asserted, resp_valid at cycle 1 with resp_error=1, resp_data=0.
- TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles then drops, resp_error=1. A later ack is ignored and the next request proceeds normally.
- Reset asserted mid-BUS, then ack pulsed after release -> mem_req drops asynchronously, no resp_valid, req_ready=1, unit accepts the next request.
